// File: rtl/secuenciador_alu.sv
// secuenciador_alu: registered command/response front end for the
// combinational unidad_logico_aritmetica.
module secuenciador_alu #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [3:0]   cmd_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_resultado,
    input  logic         alu_neg,
    input  logic         alu_cero,
    input  logic         alu_ovf,
    input  logic         alu_carry,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_resultado,
    output logic [3:0]   rsp_flags,
    output logic         rsp_error,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         illegal_q, illegal_d;
    logic         cmd_ready_d;
    logic [N-1:0] alu_a_d, alu_b_d;
    logic [3:0]   alu_ctrl_d;
    logic         rsp_valid_d;
    logic [N-1:0] rsp_res_d;
    logic [3:0]   rsp_flags_d;
    logic         rsp_error_d;
    logic [7:0]   op_count_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and next values of every registered output.
    // An illegal opcode spends one cycle in WAIT with its zeroed,
    // error-marked response already loaded, so it answers one edge
    // after acceptance without ever sampling the ALU.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_ctrl_d  = alu_ctrl;
        rsp_valid_d = rsp_valid;
        rsp_res_d   = rsp_resultado;
        rsp_flags_d = rsp_flags;
        rsp_error_d = rsp_error;
        op_count_d  = op_count;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    alu_a_d    = cmd_a;
                    alu_b_d    = cmd_b;
                    alu_ctrl_d = cmd_op;
                    illegal_d  = (cmd_op >= 4'hE);
                    state_d    = WAIT;
                    if (cmd_op >= 4'hE) begin
                        cnt_d       = 4'd1;
                        rsp_error_d = 1'b1;
                        rsp_res_d   = '0;
                        rsp_flags_d = '0;
                    end else begin
                        cnt_d = 4'(SETTLE);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!illegal_q) begin
                        rsp_res_d   = alu_resultado;
                        rsp_flags_d = {alu_neg, alu_cero, alu_ovf, alu_carry};
                        rsp_error_d = 1'b0;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    // Datapath and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            illegal_q     <= 1'b0;
            cmd_ready     <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_ctrl      <= '0;
            rsp_valid     <= 1'b0;
            rsp_resultado <= '0;
            rsp_flags     <= '0;
            rsp_error     <= 1'b0;
            op_count      <= '0;
        end else begin
            cnt_q         <= cnt_d;
            illegal_q     <= illegal_d;
            cmd_ready     <= cmd_ready_d;
            alu_a         <= alu_a_d;
            alu_b         <= alu_b_d;
            alu_ctrl      <= alu_ctrl_d;
            rsp_valid     <= rsp_valid_d;
            rsp_resultado <= rsp_res_d;
            rsp_flags     <= rsp_flags_d;
            rsp_error     <= rsp_error_d;
            op_count      <= op_count_d;
        end
    end

endmodule

// File: tb/tb_secuenciador_alu.sv
// tb_secuenciador_alu: two sequencers (SETTLE=1 and SETTLE=3) in front of
// a behavioural ALU, checked against a transaction-level model.
module tb_secuenciador_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic [3:0] cmd_a [2];
    logic [3:0] cmd_b [2];
    logic [3:0] cmd_op [2];
    logic [3:0] alu_a [2];
    logic [3:0] alu_b [2];
    logic [3:0] alu_ctrl [2];
    logic [3:0] alu_res [2];
    logic [3:0] alu_fl [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [3:0] rsp_res [2];
    logic [3:0] rsp_flags [2];
    logic       rsp_error [2];
    logic [7:0] op_count [2];

    int n_chk = 0;
    int n_pass = 0;
    int settle [2];
    int exp_cnt [2];

    always #5 clk = ~clk;

    // Behavioural ALU: returns {result, N, Z, V, C}
    function automatic logic [7:0] alu_f(input logic [3:0] a, b, op);
        logic [4:0] s;
        logic [3:0] r;
        logic v, c;
        v = 1'b0;
        c = 1'b0;
        s = '0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~(a & b);
            4'd4: r = ~(a | b);
            4'd5: r = ~a;
            4'd6: r = a << 1;
            4'd7: r = a >> 1;
            4'd8: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd9: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = s[3:0];
                c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            default: r = b;
        endcase
        return {r, r[3], (r == 4'd0), v, c};
    endfunction

    assign {alu_res[0], alu_fl[0]} = alu_f(alu_a[0], alu_b[0], alu_ctrl[0]);
    assign {alu_res[1], alu_fl[1]} = alu_f(alu_a[1], alu_b[1], alu_ctrl[1]);

    secuenciador_alu #(.N(4), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_ctrl(alu_ctrl[0]),
        .alu_resultado(alu_res[0]),
        .alu_neg(alu_fl[0][3]), .alu_cero(alu_fl[0][2]),
        .alu_ovf(alu_fl[0][1]), .alu_carry(alu_fl[0][0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_resultado(rsp_res[0]), .rsp_flags(rsp_flags[0]),
        .rsp_error(rsp_error[0]), .op_count(op_count[0])
    );

    secuenciador_alu #(.N(4), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_ctrl(alu_ctrl[1]),
        .alu_resultado(alu_res[1]),
        .alu_neg(alu_fl[1][3]), .alu_cero(alu_fl[1][2]),
        .alu_ovf(alu_fl[1][1]), .alu_carry(alu_fl[1][0]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_resultado(rsp_res[1]), .rsp_flags(rsp_flags[1]),
        .rsp_error(rsp_error[1]), .op_count(op_count[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on sequencer d, with junk commands offered
    // while it is busy and `stall` cycles of response backpressure.
    task automatic do_op(input int d, input logic [3:0] a, b, op,
                         input int stall);
        int lat;
        logic [7:0] e;
        logic err;
        lat = 0;
        while (!cmd_ready[d] && lat < 20) begin
            tick();
            lat++;
        end
        chk("cmd_ready_idle", cmd_ready[d], 1);
        cmd_a[d] = a;
        cmd_b[d] = b;
        cmd_op[d] = op;
        cmd_valid[d] = 1'b1;
        tick();
        err = (op >= 4'hE);
        e = err ? 8'h00 : alu_f(a, b, op);
        chk("cmd_ready_busy", cmd_ready[d], 0);
        cmd_a[d] = ~a;
        cmd_b[d] = ~b;
        cmd_op[d] = op ^ 4'h1;
        lat = 0;
        while (!rsp_valid[d] && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, err ? 1 : settle[d]);
        chk("resultado", rsp_res[d], e[7:4]);
        chk("flags", rsp_flags[d], e[3:0]);
        chk("error", rsp_error[d], err);
        chk("alu_a_held", alu_a[d], a);
        chk("alu_ctrl_held", alu_ctrl[d], op);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("bp_valid", rsp_valid[d], 1);
            chk("bp_res", rsp_res[d], e[7:4]);
            chk("bp_ready", cmd_ready[d], 0);
        end
        rsp_ready[d] = 1'b1;
        tick();
        rsp_ready[d] = 1'b0;
        cmd_valid[d] = 1'b0;
        exp_cnt[d] = (exp_cnt[d] + 1) % 256;
        chk("rsp_drop", rsp_valid[d], 0);
        chk("op_count", op_count[d], exp_cnt[d]);
        chk("ready_after", cmd_ready[d], 1);
    endtask

    initial begin
        int seen;
        settle[0] = 1;
        settle[1] = 3;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_a[d] = '0;
            cmd_b[d] = '0;
            cmd_op[d] = '0;
            rsp_ready[d] = 1'b0;
            exp_cnt[d] = 0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", cmd_ready[d], 0);
            chk("rst_valid", rsp_valid[d], 0);
            chk("rst_count", op_count[d], 0);
            chk("rst_alu_a", alu_a[d], 0);
        end
        rst_n = 1'b1;
        chk("ready_before_edge", cmd_ready[0], 0);
        tick();
        chk("ready_first_edge", cmd_ready[0], 1);
        chk("ready_first_edge1", cmd_ready[1], 1);

        do_op(0, 4'hA, 4'h6, 4'h0, 0);
        do_op(0, 4'hA, 4'h6, 4'h8, 0);
        do_op(1, 4'hA, 4'h6, 4'h9, 0);
        do_op(0, 4'hA, 4'h6, 4'h1, 5);
        do_op(0, 4'hA, 4'h6, 4'hE, 0);
        do_op(1, 4'h3, 4'h5, 4'hF, 1);

        for (int i = 0; i < 40; i++) begin
            do_op($urandom_range(0, 1), 4'($urandom), 4'($urandom),
                  4'($urandom), $urandom_range(0, 3));
        end

        // Illegal op then a legal op aborted by reset mid-WAIT
        do_op(1, 4'h1, 4'h2, 4'hE, 0);
        cmd_a[1] = 4'h7;
        cmd_b[1] = 4'h1;
        cmd_op[1] = 4'h8;
        cmd_valid[1] = 1'b1;
        tick();
        cmd_valid[1] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        chk("abort_valid", rsp_valid[1], 0);
        chk("abort_count", op_count[1], 0);
        chk("abort_ready", cmd_ready[1], 0);
        chk("abort_alu_a", alu_a[1], 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid[1]) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        chk("abort_count_after", op_count[1], 0);
        do_op(1, 4'h7, 4'h1, 4'h8, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
